// File: rtl/ooo_pkg.sv
// Shared types for the fetch-side blocks of the core.
// Holds address/instruction types and the instruction cache FSM states.
package ooo_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REFILL
    } icache_state_e;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data array: one synchronous write port,
// one combinational read port, no reset on contents.
module icache_data_ram
    import ooo_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  instr_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output instr_t        o_rdata
);

    instr_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with single-line refill over a req/resp bus.
// Define ICACHE_PERF_EN to build the hit/miss event counters.
module icache
    import ooo_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        flush,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TB = 30 - WB - IB;
    localparam int AW = WB + IB;

    icache_state_e r_state;
    icache_state_e w_next;

    logic [NUM_LINES-1:0] r_valid;
    logic [TB-1:0]        r_tag [NUM_LINES];
    logic [IB-1:0]        r_miss_idx;
    logic [TB-1:0]        r_miss_tag;
    addr_t                r_req_addr;
    logic [WB-1:0]        r_beat;
    logic                 r_kill;
    logic                 r_instr_valid;
    instr_t               r_instr;

    logic [WB-1:0] w_pc_word;
    logic [IB-1:0] w_pc_idx;
    logic [TB-1:0] w_pc_tag;
    logic          w_lookup;
    logic          w_hit;
    logic          w_miss;
    logic          w_beat;
    logic          w_last;
    instr_t        w_rdata;
    logic          w_unused;

    assign w_pc_word = pc_in[2 +: WB];
    assign w_pc_idx  = pc_in[2+WB +: IB];
    assign w_pc_tag  = pc_in[31 -: TB];
    assign w_unused  = ^pc_in[1:0];

    // Flush in IDLE takes priority over the lookup.
    assign w_lookup = (r_state == IDLE) && !flush;
    assign w_hit    = w_lookup && r_valid[w_pc_idx]
                    && (r_tag[w_pc_idx] == w_pc_tag);
    assign w_miss   = w_lookup && !w_hit;
    assign w_beat   = (r_state == REFILL) && mem_resp_valid;
    assign w_last   = w_beat && (r_beat == WB'(LINE_WORDS - 1));

    icache_data_ram #(
        .DEPTH (NUM_LINES * LINE_WORDS),
        .AW    (AW)
    ) u_data (
        .clk     (clk),
        .i_we    (w_beat),
        .i_waddr ({r_miss_idx, r_beat}),
        .i_wdata (mem_resp_data),
        .i_raddr ({w_pc_idx, w_pc_word}),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_miss) w_next = REQ;
            REQ:     if (mem_req_ready) w_next = REFILL;
            REFILL:  if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= '0;
            r_beat        <= '0;
            r_kill        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_req_addr    <= '0;
        end else begin
            r_instr_valid <= w_hit;
            if (w_hit) begin
                r_instr <= w_rdata;
            end
            if (w_miss) begin
                r_req_addr <= {pc_in[31:WB+2], {(WB+2){1'b0}}};
            end
            if (w_beat) begin
                r_beat <= r_beat + 1'b1;
            end
            if (flush) begin
                r_valid <= '0;
            end else if (w_last && !r_kill) begin
                r_valid[r_miss_idx] <= 1'b1;
            end
            // A flush while the bus is busy poisons the line being filled.
            if (w_last) begin
                r_kill <= 1'b0;
            end else if (flush && (r_state != IDLE)) begin
                r_kill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_miss) begin
            r_miss_idx <= w_pc_idx;
            r_miss_tag <= w_pc_tag;
        end
        if (w_last) begin
            r_tag[r_miss_idx] <= r_miss_tag;
        end
    end

    assign instr_out     = r_instr;
    assign instr_valid   = r_instr_valid;
    assign mem_req_valid = (r_state == REQ);
    assign mem_req_addr  = r_req_addr;

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hits;
    logic [31:0] r_misses;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if (w_hit) r_hits <= r_hits + 32'd1;
            if (w_miss) r_misses <= r_misses + 32'd1;
        end
    end

    assign perf_hits   = r_hits;
    assign perf_misses = r_misses;
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for the icache block.
// Inputs change and outputs are sampled on the falling edge.
module tb_icache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    icache dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .perf_hits      (perf_hits),
        .perf_misses    (perf_misses)
    );

    // Memory responder: accepts the pending request, returns base+0..3.
    task automatic serve(input logic [31:0] base, input bit gap);
        int n;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!mem_req_valid) begin
            n_bad++;
            $display("FAIL serve_req_timeout got valid=%0b want 1", mem_req_valid);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (gap) begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = 32'hBAD0_0000;
                @(negedge clk);
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(b);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_instr got v=%0b d=%h want 0/0", instr_valid, instr_out);
        end
        n_cmp++;
        if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mem got v=%0b a=%h want 0/0", mem_req_valid, mem_req_addr);
        end
        n_cmp++;
        if (perf_hits !== 32'h0 || perf_misses !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_perf got %h/%h want 0/0", perf_hits, perf_misses);
        end
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        pc_in = 32'h100;
        @(negedge clk);
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cold_req got v=%0b a=%h iv=%0b want 1/100/0", mem_req_valid, mem_req_addr, instr_valid);
        end
        serve(32'hA0, 1'b0);
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cold_idle_iv got %0b want 0", instr_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hA0) begin
            n_bad++;
            $display("FAIL cold_hit got v=%0b d=%h want 1/a0", instr_valid, instr_out);
        end
    endtask

    task automatic test_hit_stream();
        logic [31:0] pcs [3];
        logic [31:0] exp [3];
        pcs = '{32'h104, 32'h108, 32'h10C};
        exp = '{32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 3; i++) begin
            pc_in = pcs[i];
            @(negedge clk);
            n_cmp++;
            if (instr_valid !== 1'b1 || instr_out !== exp[i] || mem_req_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stream_%0d got v=%0b d=%h rq=%0b want 1/%h/0", i, instr_valid, instr_out, mem_req_valid, exp[i]);
            end
        end
    endtask

    task automatic test_conflict();
        pc_in = 32'h500;
        @(negedge clk);
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h500) begin
            n_bad++;
            $display("FAIL conflict_req got v=%0b a=%h want 1/500", mem_req_valid, mem_req_addr);
        end
        serve(32'hB0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hB0) begin
            n_bad++;
            $display("FAIL conflict_hit got v=%0b d=%h want 1/b0", instr_valid, instr_out);
        end
        pc_in = 32'h100;
        @(negedge clk);
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_remiss got v=%0b a=%h iv=%0b want 1/100/0", mem_req_valid, mem_req_addr, instr_valid);
        end
        serve(32'hA0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        pc_in = 32'h208;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_0000 + 32'(i);
            @(negedge clk);
            n_cmp++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200) begin
                n_bad++;
                $display("FAIL bp_hold_%0d got v=%0b a=%h want 1/200", i, mem_req_valid, mem_req_addr);
            end
        end
        mem_resp_valid = 1'b0;
        serve(32'hC0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hC2) begin
            n_bad++;
            $display("FAIL bp_word2 got v=%0b d=%h want 1/c2", instr_valid, instr_out);
        end
        pc_in = 32'h20C;
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hC3) begin
            n_bad++;
            $display("FAIL bp_word3 got v=%0b d=%h want 1/c3", instr_valid, instr_out);
        end
    endtask

    task automatic test_flush();
        pc_in = 32'h300;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hD0 + 32'(b);
            flush          = (b == 2);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        flush = 1'b0;
        n_cmp++;
        if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_done got rq=%0b iv=%0b want 0/0", mem_req_valid, instr_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_remiss got v=%0b a=%h iv=%0b want 1/300/0", mem_req_valid, mem_req_addr, instr_valid);
        end
        serve(32'hD0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hD0) begin
            n_bad++;
            $display("FAIL flush_refill_hit got v=%0b d=%h want 1/d0", instr_valid, instr_out);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle got iv=%0b rq=%0b want 0/0", instr_valid, mem_req_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300) begin
            n_bad++;
            $display("FAIL flush_idle_miss got v=%0b a=%h want 1/300", mem_req_valid, mem_req_addr);
        end
        serve(32'hD0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_refill();
        pc_in = 32'h400;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hE0 + 32'(b);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_out got rq=%0b iv=%0b want 0/0", mem_req_valid, instr_valid);
        end
        n_cmp++;
        if (perf_hits !== 32'h0 || perf_misses !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid_perf got %h/%h want 0/0", perf_hits, perf_misses);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h400) begin
            n_bad++;
            $display("FAIL rst_mid_remiss got v=%0b a=%h want 1/400", mem_req_valid, mem_req_addr);
        end
        serve(32'hE0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hE0) begin
            n_bad++;
            $display("FAIL rst_mid_hit got v=%0b d=%h want 1/e0", instr_valid, instr_out);
        end
`ifdef ICACHE_PERF_EN
        n_cmp++;
        if (perf_hits !== 32'd1 || perf_misses !== 32'd1) begin
            n_bad++;
            $display("FAIL perf_count got %0d/%0d want 1/1", perf_hits, perf_misses);
        end
`else
        n_cmp++;
        if (perf_hits !== 32'd0 || perf_misses !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_tied got %0d/%0d want 0/0", perf_hits, perf_misses);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_conflict();
        test_backpressure();
        test_flush();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
